message_unpad: RTL and testbench
================================

# message_unpad

Receive-side counterpart of the message padding stage. Accepts a stream of padded 512-bit blocks (data, single `1` end marker, zero fill, 64-bit big-endian bit-length in bits [63:0] of the final block), strips the padding, and emits the original message words plus a separate size record. It sits between the block-stream interface and any consumer that needs the raw message back, such as a loopback checker or a receive-path buffer.

## Interface
Parameters: none; block width is fixed at 512 bits and the length field at 64 bits.

- `clk`  in  1  clock; all logic is on the rising edge.
- `sync_rst`  in  1  synchronous, active-high reset.
- `data_in`  in  512  padded block; bit 511 is the first message bit.
- `data_in_last`  in  1  marks the final block of the message, which carries the length field.
- `data_in_valid`  in  1  input valid.
- `data_in_ready`  out  1  input ready.
- `data_out`  out  512  message word; bits below the message end are zero on the final word.
- `data_out_last`  out  1  final message word.
- `data_out_valid`  out  1  output valid.
- `data_out_ready`  in  1  output ready.
- `size_out`  out  64  recovered message length L, in bits.
- `size_err`  out  1  framing error flag for the message.
- `size_valid`  out  1  size record valid.
- `size_ready`  in  1  size record ready.

## Operation
- **Handshakes.** A transfer happens when valid && ready. Once asserted, valid and the payload hold until the transfer.
- **Length decode.** On the final block: L = `data_in[63:0]`, full = L[63:9], rem = L[8:0].
- **Expected block count.** E = full + 1 + (rem >= 448).
- **Block counter.** `blk_cnt` is 55 bits. It counts accepted blocks, including the last one, and clears after each message.
- **Final-word mask.** If rem != 0, keep the top rem bits and zero the rest. If rem == 0, keep all 512 bits.

States:

- **EMPTY** (no held word)
  - Non-last block: store it in `held` and go to HOLD.
  - Last block, 1 <= rem <= 447: emit the masked block with last=1.
  - Last block, rem == 0 or rem >= 448: emit no data word.
- **HOLD** (one word in `held`)
  - Non-last block: move `held` to the output with last=0, store the new block, stay in HOLD.
  - Last block, 1 <= rem <= 447: emit `held` with last=0, store the masked final block, go to FLUSH.
  - Last block, rem == 0 or rem >= 448: emit `held` masked with last=1, discard the final block, go to EMPTY.
- **FLUSH.** When the output slot frees, emit the stored word with last=1 and go to EMPTY.

Size record:

- Loaded with `size_out` = L when the message's last-flagged `data_out` word is loaded. If no data word is emitted, it is loaded at acceptance of the final block.
- `size_err` = (`blk_cnt` != E) || marker missing.
- Expected marker position:
  - rem in 1..447: final block bit 511-rem.
  - rem >= 448: held word bit 511-rem.
  - rem == 0 and L > 0: final block bit 511.
  - L == 0: final block bit 511.
- The data path is unchanged on error. The error only sets the flag.

## Timing
- **Input ready (combinational).** `data_in_ready` = (state != FLUSH) && (!`data_out_valid` || `data_out_ready`) && (!`size_valid` || `size_ready`).
- **Latency.** The first output word appears on `data_out` in the cycle after the second block is accepted, or after the final block for single-block messages.
- **Throughput.** One block per cycle with both consumers ready.
- **Extra cycle.** Each message with 1 <= rem <= 447 and at least two blocks adds one FLUSH cycle.
- **Reset values.** On `sync_rst`, regardless of state, mid-message included:
  - state = EMPTY, `blk_cnt` = 0, `held` cleared.
  - `data_out` = 0, `data_out_last` = 0, `data_out_valid` = 0.
  - `size_out` = 0, `size_err` = 0, `size_valid` = 0.
  - `data_in_ready` evaluates to 1 in the following cycle.
- **Simultaneous events.** A transfer out of the output register and the load of a new word in the same cycle is legal; there is no bubble.
- **Size backpressure.** If `size_valid` is pending, the next block is not accepted until the size record transfers.

## Test plan
- **Exact multiple of 512.** L=1024: three blocks (B0, B1, extra block 0x8000…_0400) -> two `data_out` words, B0 (last=0) then B1 unmasked (last=1); `size_out` = 1024, err = 0.
- **Size fits in last block.** L=600, rem=88: two blocks -> B0, then B1 with the top 88 bits kept and the rest zero (last=1, via FLUSH); `size_out` = 600, err = 0.
- **Size needs extra block.** L=460, rem=460: two blocks (data, then zeros + length) -> one word, top 460 bits kept (last=1); err = 0.
- **Zero-length message.** L=0: one block 0x8000…0 -> no data word; `size_out` = 0, err = 0.
- **Framing error.** L=600 sent as three blocks -> three data words still emitted; err = 1. Separately, clear the marker bit -> err = 1.
- **Backpressure and reset.**
  - Random `data_out_ready` and `size_ready`: no word is lost or duplicated; payload stays stable while valid && !ready.
  - `sync_rst` asserted in HOLD: all outputs return to their reset values next cycle; the next message decodes cleanly.

Source files
------------

// File: rtl/message_unpad.sv
// rtl/message_unpad.sv - strips 512-bit block padding, emits message words plus a size record
// Holds one block back so the word preceding a fill-only final block can be masked and flagged last.
module message_unpad (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [511:0] data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic [63:0]  size_out,
  output logic         size_err,
  output logic         size_valid,
  input  logic         size_ready
);

  typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;

  state_t       state, state_nxt;
  logic [511:0] held;
  logic [54:0]  blk_cnt;
  logic [63:0]  pend_size;
  logic         pend_err;

  logic         out_free, size_free, in_fire;
  logic [63:0]  len;
  logic [54:0]  full;
  logic [8:0]   rem;
  logic         rem_zero, rem_hi, rem_mid;
  logic [55:0]  exp_cnt, got_cnt;
  logic [8:0]   mark_idx;
  logic         marker, msg_err;
  logic [511:0] mask;

  logic         out_load, out_last, held_load, size_load, size_word_err;
  logic         pend_load, cnt_clr, cnt_inc;
  logic [511:0] out_word, held_word;
  logic [63:0]  size_word;

  assign out_free      = !data_out_valid || data_out_ready;
  assign size_free     = !size_valid || size_ready;
  assign data_in_ready = (state != FLUSH) && out_free && size_free;
  assign in_fire       = data_in_valid && data_in_ready;

  assign len      = data_in[63:0];
  assign full     = len[63:9];
  assign rem      = len[8:0];
  assign rem_zero = (rem == 9'd0);
  assign rem_hi   = (rem >= 9'd448);
  assign rem_mid  = !rem_zero && !rem_hi;

  // Count includes the final block being accepted this cycle.
  assign exp_cnt  = {1'b0, full} + 56'd1 + {55'd0, rem_hi};
  assign got_cnt  = {1'b0, blk_cnt} + 56'd1;
  assign mark_idx = 9'd511 - rem;
  assign marker   = rem_hi ? ((state == HOLD) && held[mark_idx]) : data_in[mark_idx];
  assign msg_err  = (got_cnt != exp_cnt) || !marker;
  assign mask     = rem_zero ? {512{1'b1}} : ~({512{1'b1}} >> rem);

  always_ff @(posedge clk) begin
    if (sync_rst) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    out_load      = 1'b0;
    out_word      = '0;
    out_last      = 1'b0;
    held_load     = 1'b0;
    held_word     = '0;
    size_load     = 1'b0;
    size_word     = '0;
    size_word_err = 1'b0;
    pend_load     = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        if (!data_in_last) begin
          held_load = 1'b1;
          held_word = data_in;
          cnt_inc   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_clr       = 1'b1;
          size_load     = 1'b1;
          size_word     = len;
          size_word_err = msg_err;
          if (rem_mid) begin
            out_load = 1'b1;
            out_word = data_in & mask;
            out_last = 1'b1;
          end
        end
      end
      HOLD: if (in_fire) begin
        out_load = 1'b1;
        out_word = held;
        if (!data_in_last) begin
          held_load = 1'b1;
          held_word = data_in;
          cnt_inc   = 1'b1;
        end else if (rem_mid) begin
          cnt_clr   = 1'b1;
          held_load = 1'b1;
          held_word = data_in & mask;
          pend_load = 1'b1;
          state_nxt = FLUSH;
        end else begin
          // Final block is pure fill: the held word is the message tail.
          cnt_clr       = 1'b1;
          out_word      = held & mask;
          out_last      = 1'b1;
          size_load     = 1'b1;
          size_word     = len;
          size_word_err = msg_err;
          state_nxt     = EMPTY;
        end
      end
      FLUSH: if (out_free && size_free) begin
        out_load      = 1'b1;
        out_word      = held;
        out_last      = 1'b1;
        size_load     = 1'b1;
        size_word     = pend_size;
        size_word_err = pend_err;
        state_nxt     = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      blk_cnt        <= '0;
      held           <= '0;
      pend_size      <= '0;
      pend_err       <= 1'b0;
      data_out       <= '0;
      data_out_last  <= 1'b0;
      data_out_valid <= 1'b0;
      size_out       <= '0;
      size_err       <= 1'b0;
      size_valid     <= 1'b0;
    end else begin
      if (cnt_clr)      blk_cnt <= '0;
      else if (cnt_inc) blk_cnt <= blk_cnt + 55'd1;
      if (held_load) held <= held_word;
      if (pend_load) begin
        pend_size <= len;
        pend_err  <= msg_err;
      end
      if (out_load) begin
        data_out       <= out_word;
        data_out_last  <= out_last;
        data_out_valid <= 1'b1;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end
      if (size_load) begin
        size_out   <= size_word;
        size_err   <= size_word_err;
        size_valid <= 1'b1;
      end else if (size_ready) begin
        size_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_message_unpad.sv
// tb/tb_message_unpad.sv - randomized bench for message_unpad against a block-list reference model
module tb_message_unpad;

  logic         clk = 1'b0;
  logic         sync_rst;
  logic [511:0] data_in;
  logic         data_in_last, data_in_valid, data_in_ready;
  logic [511:0] data_out;
  logic         data_out_last, data_out_valid;
  logic         data_out_ready = 1'b1;
  logic [63:0]  size_out;
  logic         size_err, size_valid;
  logic         size_ready = 1'b1;

  always #5 clk = ~clk;

  message_unpad dut (
    .clk(clk), .sync_rst(sync_rst),
    .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_last(data_out_last), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .size_out(size_out), .size_err(size_err), .size_valid(size_valid), .size_ready(size_ready)
  );

  typedef struct packed { logic [511:0] d; logic last; } word_t;

  word_t        exp_w[$];
  logic [64:0]  exp_s[$];
  logic [511:0] blk[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           rmode = 0;

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [511:0] keep_top(input logic [511:0] w, input int nb);
    for (int b = 0; b < 512; b++)
      if (b < 512 - nb) w[b] = 1'b0;
    return w;
  endfunction

  // Standard padding: message bits, a 1 at position L, zeros, 64-bit length at the very end.
  task automatic build(input int len);
    int n;
    logic [511:0] w;
    n = (len + 65 + 511) / 512;
    blk.delete();
    for (int i = 0; i < n; i++) begin
      int nb;
      for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
      nb = len - i * 512;
      if (nb < 0) nb = 0;
      if (nb > 512) nb = 512;
      w = keep_top(w, nb);
      if (i == len / 512) w[511 - (len % 512)] = 1'b1;
      if (i == n - 1) w[63:0] = 64'(len);
      blk.push_back(w);
    end
  endtask

  task automatic apply_fault(input int kind);
    logic [511:0] w;
    int len;
    len = int'(blk[blk.size()-1][63:0]);
    case (kind)
      1: begin
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
        blk.push_front(w);
      end
      2: blk[len / 512][511 - (len % 512)] = 1'b0;
      3: if (blk.size() > 1) void'(blk.pop_front());
      default: ;
    endcase
  endtask

  // Expected outputs derived purely from the block list and its length field.
  task automatic expect_msg(input bit push, output int nw, output bit err);
    int n, len, rem, e;
    bit mk;
    word_t w;
    n   = blk.size();
    len = int'(blk[n-1][63:0]);
    rem = len % 512;
    e   = len / 512 + 1 + ((rem >= 448) ? 1 : 0);
    if (rem == 0)       mk = blk[n-1][511];
    else if (rem < 448) mk = blk[n-1][511 - rem];
    else                mk = (n >= 2) ? blk[n-2][511 - rem] : 1'b0;
    err = (n != e) || !mk;
    nw  = 0;
    for (int i = 0; i < n - 1; i++) begin
      w.d = blk[i];
      w.last = 1'b0;
      if ((rem == 0 || rem >= 448) && i == n - 2) begin
        w.d = keep_top(blk[i], (rem == 0) ? 512 : rem);
        w.last = 1'b1;
      end
      if (push) exp_w.push_back(w);
      nw++;
    end
    if (rem > 0 && rem < 448) begin
      w.d = keep_top(blk[n-1], rem);
      w.last = 1'b1;
      if (push) exp_w.push_back(w);
      nw++;
    end
    if (push) exp_s.push_back({64'(len), err});
  endtask

  task automatic drive(input logic [511:0] d, input bit last);
    int t;
    data_in = d;
    data_in_last = last;
    data_in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (data_in_ready) break;
      t++;
      if (t > 300) begin
        n_vec++; n_bad++;
        $display("FAIL input_timeout: data_in_ready low for %0d cycles, want a transfer", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in_last = 1'b0;
  endtask

  task automatic send_blk();
    for (int i = 0; i < blk.size(); i++) drive(blk[i], i == blk.size() - 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_w.size() != 0 || exp_s.size() != 0) begin
      @(posedge clk);
      t++;
      if (t > 2000) begin
        n_vec++; n_bad++;
        $display("FAIL drain_timeout: %0d words and %0d sizes outstanding, want 0", exp_w.size(), exp_s.size());
        exp_w.delete();
        exp_s.delete();
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, {data_out, data_out_last, data_out_valid}, '0);
    check({tag, "_size"}, {size_out, size_err, size_valid}, '0);
    check({tag, "_in_ready"}, data_in_ready, 1'b1);
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: begin
        data_out_ready = ($urandom_range(0, 2) != 0);
        size_ready     = ($urandom_range(0, 2) != 0);
      end
      2: begin
        data_out_ready = 1'b0;
        size_ready     = 1'b1;
      end
      default: begin
        data_out_ready = 1'b1;
        size_ready     = 1'b1;
      end
    endcase
  end

  bit          o_stall = 0, s_stall = 0;
  logic [512:0] o_prev;
  logic [64:0]  s_prev;

  always @(negedge clk) begin
    if (sync_rst) begin
      o_stall = 0;
      s_stall = 0;
    end else begin
      if (o_stall) check("out_hold", {data_out_valid, data_out, data_out_last}, {1'b1, o_prev});
      if (s_stall) check("size_hold", {size_valid, size_out, size_err}, {1'b1, s_prev});
      if (data_out_valid && data_out_ready) begin
        if (exp_w.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL extra_word: got %0h last %0b, want no word", data_out, data_out_last);
        end else check("data_word", {data_out, data_out_last}, exp_w.pop_front());
      end
      if (size_valid && size_ready) begin
        if (exp_s.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL extra_size: got %0d err %0b, want no record", size_out, size_err);
        end else check("size_rec", {size_out, size_err}, exp_s.pop_front());
      end
      o_stall = data_out_valid && !data_out_ready;
      s_stall = size_valid && !size_ready;
      o_prev  = {data_out, data_out_last};
      s_prev  = {size_out, size_err};
    end
  end

  typedef struct { int len; int fault; int nw; bit err; } case_t;
  case_t cases[9] = '{
    '{1024, 0, 2, 1'b0}, '{600, 0, 2, 1'b0}, '{460, 0, 1, 1'b0}, '{0, 0, 0, 1'b0},
    '{600, 1, 3, 1'b1},  '{600, 2, 2, 1'b1}, '{512, 0, 1, 1'b0}, '{448, 0, 1, 1'b0},
    '{447, 0, 1, 1'b0}
  };
  int edges[10] = '{0, 1, 447, 448, 511, 512, 513, 959, 960, 1024};

  initial begin
    int nw;
    bit err;
    logic [511:0] lit;
    sync_rst = 1'b1;
    data_in = '0;
    data_in_last = 1'b0;
    data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sync_rst = 1'b0;
    check_reset_vals("reset");

    foreach (cases[c]) begin
      build(cases[c].len);
      apply_fault(cases[c].fault);
      if (cases[c].len == 1024) begin
        lit = {1'b1, 447'd0, 64'd1024};
        check("pin1024_nblk", blk.size(), 3);
        check("pin1024_final", blk[2], lit);
      end
      if (cases[c].len == 0) begin
        lit = {1'b1, 511'd0};
        check("pin0_block", blk[0], lit);
      end
      expect_msg(1'b1, nw, err);
      check($sformatf("pin_nw_L%0d_f%0d", cases[c].len, cases[c].fault), nw, cases[c].nw);
      check($sformatf("pin_err_L%0d_f%0d", cases[c].len, cases[c].fault), err, cases[c].err);
      send_blk();
      wait_idle();
    end

    rmode = 1;
    for (int m = 0; m < 60; m++) begin
      int len, fk;
      len = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 9)] : int'($urandom_range(0, 2100));
      fk  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      build(len);
      apply_fault(fk);
      expect_msg(1'b1, nw, err);
      send_blk();
    end
    wait_idle();

    // Abort a message while a word is stalled in the output register and another is held.
    rmode = 2;
    repeat (2) @(posedge clk);
    #1;
    build(1300);
    drive(blk[0], 1'b0);
    drive(blk[1], 1'b0);
    sync_rst = 1'b1;
    @(posedge clk);
    #1;
    sync_rst = 1'b0;
    check_reset_vals("midmsg_reset");
    rmode = 0;
    build(700);
    expect_msg(1'b1, nw, err);
    check("post_reset_err", err, 1'b0);
    send_blk();
    wait_idle();

    check("left_words", exp_w.size(), 0);
    check("left_sizes", exp_s.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
